// File: rtl/br_pred_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : br_pred_gshare
//  Purpose  : Gshare conditional-branch direction predictor. A table of
//             saturating counters is indexed by PC XOR global history. The
//             speculative history shifts at fetch. The architectural history
//             shifts at commit. Mispredicts and flushes repair the
//             speculative history from the architectural one.
//  Revision : 1.0  initial release
// ============================================================================
module br_pred_gshare #(
  parameter int ADDR     = 32,
  parameter int CNT      = 2,
  parameter int DEPTH    = 1024,
  parameter int GHR      = 10,
  parameter int ADDR_OFS = 2
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            flush_,
  input  logic [ADDR-1:0] br_pc,
  input  logic            br_valid_,
  output logic            br_pred,
  output logic [GHR-1:0]  br_ghr,
  input  logic [ADDR-1:0] commit_pc,
  input  logic [GHR-1:0]  commit_ghr,
  input  logic            br_commit_,
  input  logic            br_result,
  input  logic            br_pred_miss_
);

  localparam int PTR = $clog2(DEPTH);

  localparam logic [CNT-1:0] c_cnt_weak = {1'b1, {(CNT-1){1'b0}}};
  localparam logic [CNT-1:0] c_cnt_max  = {CNT{1'b1}};
  localparam logic [CNT-1:0] c_cnt_one  = CNT'(1);

  logic [CNT-1:0] r_cnt [DEPTH];
  logic [GHR-1:0] r_spec_ghr;
  logic [GHR-1:0] r_arch_ghr;

  logic [PTR-1:0] w_spec_ext;
  logic [PTR-1:0] w_commit_ext;
  logic [PTR-1:0] w_pred_idx;
  logic [PTR-1:0] w_upd_idx;
  logic [CNT-1:0] w_pred_cnt;
  logic [CNT-1:0] w_upd_cnt;
  logic [CNT-1:0] w_cnt_next;
  logic [GHR:0]   w_spec_wide;
  logic [GHR:0]   w_arch_wide;
  logic [GHR-1:0] w_spec_shift;
  logic [GHR-1:0] w_arch_next;
  logic [GHR-1:0] w_spec_next;
  logic           w_unused_pc;

  // PC bits outside the index window do not take part in the hash.
  assign w_unused_pc = ^{br_pc, commit_pc};

  // Zero-extend both histories to the index width (GHR may equal PTR).
  always_comb begin
    w_spec_ext               = '0;
    w_spec_ext[GHR-1:0]      = r_spec_ghr;
    w_commit_ext             = '0;
    w_commit_ext[GHR-1:0]    = commit_ghr;
  end

  assign w_pred_idx = br_pc[PTR+ADDR_OFS-1:ADDR_OFS] ^ w_spec_ext;
  assign w_upd_idx  = commit_pc[PTR+ADDR_OFS-1:ADDR_OFS] ^ w_commit_ext;

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign w_pred_cnt = r_cnt[w_pred_idx];
  assign br_pred    = w_pred_cnt[CNT-1];
  assign br_ghr     = r_spec_ghr;

  // Shift-in through a one-bit-wider vector so GHR = 1 needs no special case.
  assign w_spec_wide  = {r_spec_ghr, br_pred};
  assign w_spec_shift = w_spec_wide[GHR-1:0];
  assign w_arch_wide  = {r_arch_ghr, br_result};
  assign w_arch_next  = br_commit_ ? r_arch_ghr : w_arch_wide[GHR-1:0];

  // Saturating increment/decrement of the counter addressed by the commit.
  always_comb begin
    w_upd_cnt  = r_cnt[w_upd_idx];
    w_cnt_next = w_upd_cnt;
    if (br_result) begin
      if (w_upd_cnt != c_cnt_max) w_cnt_next = w_upd_cnt + c_cnt_one;
    end else begin
      if (w_upd_cnt != '0) w_cnt_next = w_upd_cnt - c_cnt_one;
    end
  end

  // Speculative history source: mispredict repair, then flush, then fetch shift.
  always_comb begin
    w_spec_next = r_spec_ghr;
    if (!br_commit_ && !br_pred_miss_) w_spec_next = w_arch_next;
    else if (!flush_)                  w_spec_next = w_arch_next;
    else if (!br_valid_)               w_spec_next = w_spec_shift;
  end

  // History registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_spec_ghr <= '0;
      r_arch_ghr <= '0;
    end else begin
      r_spec_ghr <= w_spec_next;
      r_arch_ghr <= w_arch_next;
    end
  end

  // Counter table: all entries weakly taken on reset, one entry trained per commit.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= c_cnt_weak;
    end else if (!br_commit_) begin
      r_cnt[w_upd_idx] <= w_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_br_pred_gshare.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_br_pred_gshare
//  Purpose  : Scoreboard bench for br_pred_gshare. Directed scenarios
//             followed by random fetch/commit/flush traffic, all checked
//             against an integer reference model of the predictor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_br_pred_gshare;

  localparam int ADDR     = 32;
  localparam int CNT      = 2;
  localparam int DEPTH    = 1024;
  localparam int GHR      = 10;
  localparam int ADDR_OFS = 2;
  localparam int CMAX     = (1 << CNT) - 1;
  localparam int CWEAK    = 1 << (CNT - 1);
  localparam int GMASK    = (1 << GHR) - 1;

  logic            clk;
  logic            reset_;
  logic            flush_;
  logic [ADDR-1:0] br_pc;
  logic            br_valid_;
  logic            br_pred;
  logic [GHR-1:0]  br_ghr;
  logic [ADDR-1:0] commit_pc;
  logic [GHR-1:0]  commit_ghr;
  logic            br_commit_;
  logic            br_result;
  logic            br_pred_miss_;

  br_pred_gshare #(
    .ADDR(ADDR), .CNT(CNT), .DEPTH(DEPTH), .GHR(GHR), .ADDR_OFS(ADDR_OFS)
  ) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_),
    .br_pc(br_pc), .br_valid_(br_valid_), .br_pred(br_pred), .br_ghr(br_ghr),
    .commit_pc(commit_pc), .commit_ghr(commit_ghr), .br_commit_(br_commit_),
    .br_result(br_result), .br_pred_miss_(br_pred_miss_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers.
  int cnt_m [DEPTH];
  int spec_m;
  int arch_m;

  typedef struct {
    logic           pred;
    logic [GHR-1:0] ghr;
    int             id;
  } exp_t;

  typedef struct {
    logic [ADDR-1:0] pc;
    logic [GHR-1:0]  ghr;
    logic            pred;
  } br_t;

  exp_t exp_q [$];
  exp_t m_e;
  int   n_cmp;
  int   n_bad;
  int   n_issue;
  logic           last_pred;
  logic [GHR-1:0] last_ghr;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) cnt_m[i] = CWEAK;
    spec_m = 0;
    arch_m = 0;
  endfunction

  // Monitor: compare every expected response against the DUT mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      n_cmp++;
      if (br_pred !== m_e.pred) begin
        n_bad++;
        $display("FAIL br_pred lookup#%0d: got %b expected %b", m_e.id, br_pred, m_e.pred);
      end
      n_cmp++;
      if (br_ghr !== m_e.ghr) begin
        n_bad++;
        $display("FAIL br_ghr lookup#%0d: got 0x%03h expected 0x%03h", m_e.id, br_ghr, m_e.ghr);
      end
    end
  end

  // One clock of stimulus: drive, predict outputs, then advance the model.
  task automatic cycle(input logic [ADDR-1:0] pc, input logic vld_n,
                       input logic com_n, input logic [ADDR-1:0] cpc,
                       input logic [GHR-1:0] cghr, input logic res,
                       input logic miss_n, input logic fl_n);
    int   idx;
    int   uidx;
    int   arch_n;
    exp_t e;
    @(posedge clk);
    #1;
    br_pc = pc; br_valid_ = vld_n; br_commit_ = com_n; commit_pc = cpc;
    commit_ghr = cghr; br_result = res; br_pred_miss_ = miss_n; flush_ = fl_n;

    idx    = (int'(pc >> ADDR_OFS) ^ spec_m) % DEPTH;
    e.pred = (cnt_m[idx] >= CWEAK);
    e.ghr  = GHR'(spec_m);
    e.id   = n_issue++;
    exp_q.push_back(e);
    last_pred = e.pred;
    last_ghr  = e.ghr;

    arch_n = arch_m;
    if (!com_n) begin
      uidx = (int'(cpc >> ADDR_OFS) ^ int'(cghr)) % DEPTH;
      if (res) cnt_m[uidx] = (cnt_m[uidx] == CMAX) ? CMAX : cnt_m[uidx] + 1;
      else     cnt_m[uidx] = (cnt_m[uidx] == 0)    ? 0    : cnt_m[uidx] - 1;
      arch_n = ((arch_m * 2) + int'(res)) & GMASK;
    end
    if ((!com_n && !miss_n) || !fl_n) spec_m = arch_n;
    else if (!vld_n)                  spec_m = ((spec_m * 2) + int'(e.pred)) & GMASK;
    arch_m = arch_n;
  endtask

  task automatic lookup(input logic [ADDR-1:0] pc, input logic vld_n);
    cycle(pc, vld_n, 1'b1, '0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic commit(input logic [ADDR-1:0] cpc, input logic [GHR-1:0] cghr,
                        input logic res, input logic miss_n);
    cycle(32'h100, 1'b1, 1'b0, cpc, cghr, res, miss_n, 1'b1);
  endtask

  // Asynchronous reset with a commit in flight; the commit must not land.
  task automatic do_reset();
    @(posedge clk);
    #1;
    br_commit_ = 1'b0; commit_pc = 32'h100; commit_ghr = '0; br_result = 1'b0;
    br_valid_ = 1'b0; br_pred_miss_ = 1'b0;
    #1 reset_ = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    br_commit_ = 1'b1; br_valid_ = 1'b1; br_pred_miss_ = 1'b1;
    reset_ = 1'b1;
  endtask

  br_t            pend [$];
  br_t            b;
  logic [ADDR-1:0] rpc;
  logic            v_n, c_n, res, m_n, f_n;
  logic [9:0]      pat;

  initial begin
    n_cmp = 0; n_bad = 0; n_issue = 0;
    reset_ = 1'b0; flush_ = 1'b1; br_pc = '0; br_valid_ = 1'b1;
    commit_pc = '0; commit_ghr = '0; br_commit_ = 1'b1; br_result = 1'b0;
    br_pred_miss_ = 1'b1;
    model_reset();
    #12 reset_ = 1'b1;

    // Reset state, then one speculative shift.
    lookup(32'h100, 1'b0);
    lookup(32'h100, 1'b1);

    // Train down to 0 and hold there.
    do_reset();
    commit(32'h100, '0, 1'b0, 1'b1);
    commit(32'h100, '0, 1'b0, 1'b1);
    lookup(32'h100, 1'b1);
    commit(32'h100, '0, 1'b0, 1'b1);
    commit(32'h100, '0, 1'b1, 1'b1);
    lookup(32'h100, 1'b1);

    // Saturate at max; neighbour index 0x040^0x3 untouched.
    do_reset();
    repeat (4) commit(32'h100, '0, 1'b1, 1'b1);
    commit(32'h100, '0, 1'b0, 1'b1);
    lookup(32'h100, 1'b1);
    lookup(32'h10C, 1'b1);
    commit(32'h10C, '0, 1'b0, 1'b1);
    lookup(32'h10C, 1'b1);

    // Four taken lookups, then mispredict repair drops a same-cycle shift.
    do_reset();
    repeat (4) lookup(32'h100, 1'b0);
    cycle(32'h100, 1'b0, 1'b0, 32'h100, '0, 1'b0, 1'b0, 1'b1);
    lookup(32'h100, 1'b1);

    // Build arch=0x155 and copy it to spec via a mispredict, then arch=0x0AA.
    do_reset();
    pat = 10'h155;
    for (int i = 9; i >= 0; i--) commit(32'h200, '0, pat[i], (i == 0) ? 1'b0 : 1'b1);
    pat = 10'h0AA;
    for (int i = 9; i >= 0; i--) commit(32'h200, '0, pat[i], 1'b1);
    lookup(32'h100, 1'b1);
    cycle(32'h100, 1'b0, 1'b1, '0, '0, 1'b0, 1'b1, 1'b0);
    lookup(32'h100, 1'b1);
    cycle(32'h100, 1'b0, 1'b0, 32'h200, '0, 1'b1, 1'b1, 1'b0);
    lookup(32'h100, 1'b1);

    // Same-index lookup and update: old value this cycle, new value next.
    do_reset();
    commit(32'h300, '0, 1'b0, 1'b1);
    cycle(32'h300, 1'b1, 1'b0, 32'h300, '0, 1'b1, 1'b1, 1'b1);
    lookup(32'h300, 1'b1);

    // Reset mid-sequence: counters are back to weakly taken (2, not 3).
    do_reset();
    lookup(32'h300, 1'b1);
    lookup(32'h100, 1'b1);
    commit(32'h300, '0, 1'b0, 1'b1);
    commit(32'h200, '0, 1'b0, 1'b1);
    lookup(32'h300, 1'b1);
    lookup(32'h200, 1'b1);

    // Random traffic with realistic commit/mispredict/flush behaviour.
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        do_reset();
        pend.delete();
      end
      rpc = ($urandom & 32'hFFFF_0000) | (ADDR'($urandom_range(0, 63)) << 2)
            | ADDR'($urandom_range(0, 3));
      v_n = ($urandom_range(0, 3) == 0);
      c_n = 1'b1; res = 1'b0; m_n = 1'b1;
      b.pc = '0; b.ghr = '0; b.pred = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        c_n = 1'b0;
        b   = pend.pop_front();
        res = b.pc[2] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
        m_n = (res == b.pred);
      end
      f_n = ($urandom_range(0, 39) != 0);
      cycle(rpc, v_n, c_n, b.pc, b.ghr, res, m_n, f_n);
      if (!m_n || !f_n) pend.delete();
      else if (!v_n) begin
        b.pc = rpc; b.ghr = last_ghr; b.pred = last_pred;
        pend.push_back(b);
        if (pend.size() > 12) void'(pend.pop_front());
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
